// File: rtl/nib_mem_arbiter_pkg.sv
// Shared types and constants for the nib_* memory-port arbiter.
// The transaction record is sized for address/data widths up to 32 bits and up to 8 cores.
package nib_mem_arbiter_pkg;

    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_OWNER_W = 3;
    localparam logic [ARB_DATA_W-1:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [ARB_ADDR_W-1:0]  addr;
        logic [ARB_DATA_W-1:0]  wdata;
        logic [ARB_OWNER_W-1:0] owner;
    } mem_txn_t;

    function automatic logic [ARB_OWNER_W-1:0] rr_next(input logic [ARB_OWNER_W-1:0] owner,
                                                       input int n_core);
        if (int'(owner) >= n_core - 1) begin
            return '0;
        end
        return owner + 1'b1;
    endfunction

endpackage

// File: rtl/nib_rr_picker.sv
// Combinational round-robin picker: one-hot winner searching upward from ptr with wrap-around.
module nib_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nib_mem_arbiter.sv
// Round-robin arbiter sharing one nib_ex_* data-memory port between N_CORE cores,
// one outstanding access at a time, with a completion timeout.
module nib_mem_arbiter
    import nib_mem_arbiter_pkg::*;
#(
    parameter int N_CORE  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = ARB_ERR_DATA
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CORE-1:0]              core_req_i,
    input  logic [N_CORE-1:0]              core_we_i,
    input  logic [N_CORE-1:0][ADDR_W-1:0]  core_addr_i,
    input  logic [N_CORE-1:0][DATA_W-1:0]  core_wdata_i,
    output logic [N_CORE-1:0][DATA_W-1:0]  core_rdata_o,
    output logic [N_CORE-1:0]              core_done_o,
    output logic [N_CORE-1:0]              core_err_o,
    output logic [N_CORE-1:0]              core_hold_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [DATA_W-1:0]              mem_rdata_i,
    output logic                           bus_idle_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e               state_reg, state_next;
    mem_txn_t                 txn_reg, txn_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [ARB_OWNER_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [N_CORE-1:0]        done_reg, done_next;
    logic [N_CORE-1:0]        err_reg, err_next;
    logic [DATA_W-1:0]        rdata_reg [N_CORE];

    logic [N_CORE-1:0]        pick_gnt;
    logic [ARB_OWNER_W-1:0]   pick_idx;
    logic                     pick_any;
    logic                     sel_we;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;
    logic [N_CORE-1:0]        owner_hot;
    logic                     finish, abort, rd_load, rd_err;

    // A core in its done cycle still shows req; masking it keeps a finished access from being re-issued.
    assign core_hold_o = core_req_i & ~done_reg;

    nib_rr_picker #(
        .N     (N_CORE),
        .IDX_W (ARB_OWNER_W)
    ) u_picker (
        .req (core_hold_o),
        .ptr (rr_ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        owner_hot = '0;
        for (int k = 0; k < N_CORE; k++) begin
            if (pick_gnt[k]) begin
                sel_we    = core_we_i[k];
                sel_addr  = core_addr_i[k];
                sel_wdata = core_wdata_i[k];
            end
            owner_hot[k] = (txn_reg.owner == ARB_OWNER_W'(k));
        end
    end

    always_comb begin
        state_next  = state_reg;
        txn_next    = txn_reg;
        cnt_next    = cnt_reg;
        rr_ptr_next = rr_ptr_reg;
        done_next   = '0;
        err_next    = '0;
        finish      = 1'b0;
        abort       = 1'b0;
        rd_load     = 1'b0;
        rd_err      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    txn_next.we    = sel_we;
                    txn_next.addr  = ARB_ADDR_W'(sel_addr);
                    txn_next.wdata = ARB_DATA_W'(sel_wdata);
                    txn_next.owner = pick_idx;
                    cnt_next       = '0;
                    state_next     = REQ;
                end
            end
            REQ: begin
                if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (mem_gnt_i) begin
                        if (txn_reg.we) begin
                            finish = 1'b1;
                        end else if (mem_rvalid_i) begin
                            rd_load = 1'b1;
                            finish  = 1'b1;
                        end else begin
                            state_next = WAIT_R;
                        end
                    end
                end
            end
            WAIT_R: begin
                if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    abort = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (mem_rvalid_i) begin
                        rd_load = 1'b1;
                        finish  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            finish = 1'b1;
            rd_err = !txn_reg.we;
        end
        if (finish) begin
            state_next  = IDLE;
            rr_ptr_next = rr_next(txn_reg.owner, N_CORE);
            done_next   = owner_hot;
            err_next    = abort ? owner_hot : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            txn_reg    <= '0;
            cnt_reg    <= '0;
            rr_ptr_reg <= '0;
            done_reg   <= '0;
            err_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            txn_reg    <= txn_next;
            cnt_reg    <= cnt_next;
            rr_ptr_reg <= rr_ptr_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CORE; gi++) begin : g_rdata
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg[gi] <= '0;
                end else if ((rd_load || rd_err) && owner_hot[gi]) begin
                    rdata_reg[gi] <= rd_err ? ERR_DATA : mem_rdata_i;
                end
            end
            assign core_rdata_o[gi] = rdata_reg[gi];
        end
    endgenerate

    assign core_done_o = done_reg;
    assign core_err_o  = err_reg;
    assign mem_req_o   = (state_reg == REQ);
    assign mem_we_o    = txn_reg.we;
    assign mem_addr_o  = txn_reg.addr[ADDR_W-1:0];
    assign mem_wdata_o = txn_reg.wdata[DATA_W-1:0];
    assign bus_idle_o  = (state_reg == IDLE) && !(|core_req_i);

endmodule

// File: tb/tb_nib_mem_arbiter.sv
// Directed bench for nib_mem_arbiter: per-cycle vector table plus a hand-written stalled-grant write.
module tb_nib_mem_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0040;
    localparam logic [31:0] W0 = 32'h1234_5678;
    localparam logic [31:0] W1 = 32'h0BAD_F00D;
    localparam logic [31:0] CF = 32'hCAFE_0001;
    localparam logic [31:0] S2 = 32'h5A5A_0002;
    localparam logic [31:0] S3 = 32'h7777_0003;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       core_req, core_we;
    logic [1:0][31:0] core_addr, core_wdata, core_rdata;
    logic [1:0]       core_done, core_err, core_hold;
    logic             mem_req, mem_we, mem_gnt, mem_rvalid, bus_idle;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;

    nib_mem_arbiter #(
        .N_CORE  (2),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_rdata_o (core_rdata),
        .core_done_o  (core_done),
        .core_err_o   (core_err),
        .core_hold_o  (core_hold),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .bus_idle_o   (bus_idle)
    );

    typedef struct {
        logic [47:0] tag;
        logic        rst;
        logic [1:0]  req, we;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        mreq, mwe;
        logic [31:0] maddr;
        logic [1:0]  done, err, hold;
        logic        idle;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic add(input logic [47:0] tag, input logic r, input logic [1:0] req, input logic [1:0] we,
                       input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic mreq, input logic mwe, input logic [31:0] maddr,
                       input logic [1:0] done, input logic [1:0] err, input logic [1:0] hold,
                       input logic idle, input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.tag = tag; v.rst = r; v.req = req; v.we = we; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.mreq = mreq; v.mwe = mwe; v.maddr = maddr; v.done = done; v.err = err; v.hold = hold;
        v.idle = idle; v.rd0 = rd0; v.rd1 = rd1;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end else begin
            $display("chk %s ok (%0h)", name, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_wd;
        logic        ok;
        int          cyc;

        core_addr[0] = A0; core_addr[1] = A1;
        core_wdata[0] = W0; core_wdata[1] = W1;
        core_req = '0; core_we = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        rst = 1'b1;

        // single write, core0
        add("wr0", 0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b01, 0, 0, 0);
        add("wr0", 0, 2'b01, 2'b01, 0, 0, 0,  1, 1, A0, 2'b00, 2'b00, 2'b01, 0, 0, 0);
        add("wr0", 0, 2'b01, 2'b01, 1, 0, 0,  1, 1, A0, 2'b00, 2'b00, 2'b01, 0, 0, 0);
        add("wr0", 0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 0, 0, 0);
        add("wr0", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, 0, 0);
        // core1 read, rvalid two cycles after gnt
        add("rd1", 0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 0, 0, 0);
        add("rd1", 0, 2'b10, 2'b00, 1, 0, 0,  1, 0, A1, 2'b00, 2'b00, 2'b10, 0, 0, 0);
        add("rd1", 0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 0, 0, 0);
        add("rd1", 0, 2'b10, 2'b00, 0, 1, CF, 0, 0, 0,  2'b00, 2'b00, 2'b10, 0, 0, 0);
        add("rd1", 0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 0,  2'b10, 2'b00, 2'b00, 0, 0, CF);
        add("rd1", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, 0, CF);
        // contention, immediate gnt: order 0,1,0,1,0,1
        add("cont", 0, 2'b11, 2'b11, 1, 0, 0, 0, 0, 0,  2'b00, 2'b00, 2'b11, 0, 0, CF);
        for (int n = 0; n < 3; n++) begin
            add("cont", 0, 2'b11, 2'b11, 1, 0, 0, 1, 1, A0, 2'b00, 2'b00, 2'b11, 0, 0, CF);
            add("cont", 0, 2'b11, 2'b11, 1, 0, 0, 0, 0, 0,  2'b01, 2'b00, 2'b10, 0, 0, CF);
            add("cont", 0, 2'b11, 2'b11, 1, 0, 0, 1, 1, A1, 2'b00, 2'b00, 2'b11, 0, 0, CF);
            if (n < 2)
                add("cont", 0, 2'b11, 2'b11, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 0, 0, CF);
        end
        add("cont", 0, 2'b10, 2'b11, 1, 0, 0, 0, 0, 0,  2'b10, 2'b00, 2'b00, 0, 0, CF);
        add("cont", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 2'b00, 1, 0, CF);
        // gnt and rvalid together in the first REQ cycle
        add("rvg", 0, 2'b01, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b01, 0, 0,  CF);
        add("rvg", 0, 2'b01, 2'b00, 1, 1, S2, 1, 0, A0, 2'b00, 2'b00, 2'b01, 0, 0,  CF);
        add("rvg", 0, 2'b01, 2'b00, 0, 0, 0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 0, S2, CF);
        add("rvg", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, S2, CF);
        // timeout on a read, late rvalid in IDLE ignored
        add("tmo", 0, 2'b01, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b01, 0, S2, CF);
        add("tmo", 0, 2'b01, 2'b00, 1, 0, 0,  1, 0, A0, 2'b00, 2'b00, 2'b01, 0, S2, CF);
        for (int n = 0; n < 4; n++)
            add("tmo", 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, S2, CF);
        add("tmo", 0, 2'b01, 2'b00, 0, 0, 0,  0, 0, 0,  2'b01, 2'b01, 2'b00, 0, DB, CF);
        add("tmo", 0, 2'b00, 2'b00, 0, 1, 32'h1111_1111, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, DB, CF);
        // core1 write after the timeout
        add("wr1", 0, 2'b10, 2'b10, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 0, DB, CF);
        add("wr1", 0, 2'b10, 2'b10, 1, 0, 0,  1, 1, A1, 2'b00, 2'b00, 2'b10, 0, DB, CF);
        add("wr1", 0, 2'b10, 2'b10, 0, 0, 0,  0, 0, 0,  2'b10, 2'b00, 2'b00, 0, DB, CF);
        add("wr1", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, DB, CF);
        // owner drops req after capture; access still completes
        add("drop", 0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 0, DB, CF);
        add("drop", 0, 2'b00, 2'b00, 1, 0, 0,  1, 0, A1, 2'b00, 2'b00, 2'b00, 0, DB, CF);
        add("drop", 0, 2'b00, 2'b00, 0, 1, S3, 0, 0, 0,  2'b00, 2'b00, 2'b00, 0, DB, CF);
        add("drop", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b10, 2'b00, 2'b00, 1, DB, S3);
        add("drop", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, DB, S3);
        // reset during WAIT_R, then arbitration restarts from pointer 0
        add("rst", 0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b01, 0, DB, S3);
        add("rst", 0, 2'b01, 2'b01, 1, 0, 0,  1, 1, A0, 2'b00, 2'b00, 2'b01, 0, DB, S3);
        add("rst", 0, 2'b01, 2'b01, 0, 0, 0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 0, DB, S3);
        add("rst", 0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 0, DB, S3);
        add("rst", 0, 2'b10, 2'b00, 1, 0, 0,  1, 0, A1, 2'b00, 2'b00, 2'b10, 0, DB, S3);
        add("rst", 0, 2'b10, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 0, DB, S3);
        add("rst", 1, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, 0,  0);
        add("rst", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, 0,  0);
        add("rst", 0, 2'b11, 2'b11, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b11, 0, 0,  0);
        add("rst", 0, 2'b11, 2'b11, 1, 0, 0,  1, 1, A0, 2'b00, 2'b00, 2'b11, 0, 0,  0);
        add("rst", 0, 2'b11, 2'b11, 0, 0, 0,  0, 0, 0,  2'b01, 2'b00, 2'b10, 0, 0,  0);
        add("rst", 0, 2'b10, 2'b11, 1, 0, 0,  1, 1, A1, 2'b00, 2'b00, 2'b10, 0, 0,  0);
        add("rst", 0, 2'b10, 2'b11, 0, 0, 0,  0, 0, 0,  2'b10, 2'b00, 2'b00, 0, 0,  0);
        add("rst", 0, 2'b00, 2'b00, 0, 0, 0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1, 0,  0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {mem_req, core_done, core_err, core_hold, bus_idle, core_rdata},
            {1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 64'h0});
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; core_req = tbl[i].req; core_we = tbl[i].we;
            mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rdata;
            #1;
            exp_wd = (tbl[i].maddr == A0) ? W0 : W1;
            ok = (mem_req === tbl[i].mreq) && (core_done === tbl[i].done) && (core_err === tbl[i].err)
                 && (core_hold === tbl[i].hold) && (bus_idle === tbl[i].idle)
                 && (core_rdata[0] === tbl[i].rd0) && (core_rdata[1] === tbl[i].rd1);
            if (tbl[i].mreq)
                ok = ok && (mem_we === tbl[i].mwe) && (mem_addr === tbl[i].maddr)
                     && (!tbl[i].mwe || mem_wdata === exp_wd);
            nvec++;
            if (!ok) begin
                nfail++;
                $display("FAIL vec %0d %s got/exp: mreq=%b/%b we=%b/%b addr=%h/%h done=%b/%b err=%b/%b hold=%b/%b idle=%b/%b rd0=%h/%h rd1=%h/%h",
                         i, tbl[i].tag, mem_req, tbl[i].mreq, mem_we, tbl[i].mwe, mem_addr, tbl[i].maddr,
                         core_done, tbl[i].done, core_err, tbl[i].err, core_hold, tbl[i].hold,
                         bus_idle, tbl[i].idle, core_rdata[0], tbl[i].rd0, core_rdata[1], tbl[i].rd1);
            end else begin
                $display("vec %0d %s req=%b mreq=%b done=%b err=%b hold=%b idle=%b ok",
                         i, tbl[i].tag, core_req, mem_req, core_done, core_err, core_hold, bus_idle);
            end
        end

        // core1 write with gnt withheld for three REQ cycles: request must stay stable
        @(negedge clk);
        core_req = 2'b10; core_we = 2'b10; mem_gnt = 0; mem_rvalid = 0;
        #1;
        cyc = 0;
        while (mem_req !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("stall_latency", 128'(cyc), 128'(1));
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin
                @(negedge clk);
                #1;
            end
            chk("stall_hold", {mem_req, mem_we, mem_addr, mem_wdata, core_hold, core_done},
                {1'b1, 1'b1, A1, W1, 2'b10, 2'b00});
        end
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("stall_gnt", {mem_req, mem_addr, core_done}, {1'b1, A1, 2'b00});
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("stall_done", {mem_req, core_done, core_err, core_hold}, {1'b0, 2'b10, 2'b00, 2'b00});
        @(negedge clk);
        core_req = 2'b00; core_we = 2'b00;
        #1;
        chk("stall_idle", {bus_idle, core_done, core_rdata}, {1'b1, 2'b00, 64'h0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/nib_mem_arbiter.md
Name: nib_mem_arbiter

Overview:
- Shares the single external data-memory port (nib_ex_* style bus) between N_CORE RISC-V vector cores in the dual-core build.
- Sits between each core's nib_ex_* master interface and the memory/DMA-side slave.
- Grants one core at a time with round-robin fairness and stalls the others through their hold request.
- Captures each granted transaction, enforces one outstanding access, and returns read data and completion to the owning core.

Parameters:
- N_CORE, 2, number of requesting cores (legal 2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles allowed from mem_req_o assertion to completion before abort (>=1).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- core_req_i  in  N_CORE  per-core access request (level, held until done)
- core_we_i  in  N_CORE  per-core write enable
- core_addr_i  in  N_CORE x ADDR_W  per-core byte address
- core_wdata_i  in  N_CORE x DATA_W  per-core write data
- core_rdata_o  out  N_CORE x DATA_W  per-core registered read data
- core_done_o  out  N_CORE  one-cycle completion pulse
- core_err_o  out  N_CORE  one-cycle timeout pulse (coincides with done)
- core_hold_o  out  N_CORE  stall request to core (drives nib_hold_req_i)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_W  read data
- bus_idle_o  out  1  high when state is IDLE and no core_req_i is set

Behaviour:
- Reset values:
  - All registered outputs 0; core_rdata_o 0.
  - State IDLE; rr_ptr 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT_R.
- IDLE:
  - If any core_req_i is set, select the winner by round-robin starting at rr_ptr.
  - Capture owner, we, addr and wdata into registers; go to REQ.
  - Arbitration latency is 1 cycle: mem_req_o rises the cycle after the request is seen.
- REQ:
  - mem_req_o = 1; mem_* driven from the captured registers, stable until mem_gnt_i.
  - On mem_gnt_i with we=1: complete.
  - On mem_gnt_i with we=0: go to WAIT_R.
  - If mem_gnt_i and mem_rvalid_i arrive in the same cycle on a read, complete immediately.
- WAIT_R:
  - mem_req_o = 0.
  - On mem_rvalid_i: latch mem_rdata_i into core_rdata_o[owner]; complete.
- Complete (registered, the cycle after the event):
  - core_done_o[owner] pulses for 1 cycle.
  - rr_ptr = (owner+1) mod N_CORE.
  - Return to IDLE; a new arbitration is allowed in the same cycle the done pulse is driven.
  - Back-to-back requests from the same core therefore yield at most one access per 3 cycles (write, gnt in the first REQ cycle).
- Timeout:
  - Counter clears on entering REQ and increments in REQ and WAIT_R.
  - At count == TIMEOUT: abort. mem_req_o drops; core_rdata_o[owner] = ERR_DATA for reads; done and err pulse together; rr_ptr advances; return to IDLE.
  - A late mem_rvalid_i arriving in IDLE is ignored.
- core_hold_o (combinational): core_hold_o[i] = core_req_i[i] & ~core_done_o[i]. The owner is held until its done cycle; losers are held throughout.
- Captured transactions run to completion even if the owner drops core_req_i. The done pulse is still issued and the core ignores it.
- rdata of non-owning cores is never modified.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req_o 0, no done pulse; the memory side must tolerate an abandoned request.

Decomposition:
- Add to rvv_pkg:
  - arb_state_e enum (IDLE, REQ, WAIT_R)
  - mem_txn_t struct {we, addr, wdata, owner}
  - localparam ARB_ERR_DATA
- One sub-module, nib_rr_picker: combinational round-robin one-hot winner from a request vector and a pointer. Reusable for the instruction-fetch port.

Test Plan:
- Single write: core0 req, we=1, addr 0x100, wdata 0x1234_5678, gnt 1 cycle after mem_req_o -> mem_req_o high at cycle 1; done[0] at cycle 3; hold[0] high cycles 0-2; rr_ptr=1.
- Read, rvalid 2 cycles after gnt: core1 reads 0x40, mem returns 0xCAFE_0001 -> rdata_o[1]=0xCAFE_0001 with done[1]; rdata_o[0] unchanged.
- Contention: both cores request continuously for 6 accesses, gnt immediate -> grant order 0,1,0,1,0,1; the loser's hold stays high until its own done.
- Timeout: TIMEOUT=4, core0 read, gnt given, rvalid never -> done[0]=err[0]=1 at count 4; rdata_o[0]=0xDEAD_BEEF; a subsequent core1 request is serviced normally.
- Same-cycle gnt+rvalid: read with both asserted in the first REQ cycle -> done in the next cycle; WAIT_R never entered.
- Reset mid-op: assert rst during WAIT_R -> mem_req_o=0, no done, bus_idle_o=1 with no requests; a fresh request after release starts from rr_ptr 0.
